// File: rtl/pattern_detector_pkg.sv
// Shared types and width helpers for the multi-slot serial pattern detector.
package pattern_detector_pkg;

  // Per-slot lifecycle: no pattern, collecting bits, able to match.
  typedef enum logic [1:0] {
    SLOT_DISABLED = 2'd0,
    SLOT_FILLING  = 2'd1,
    SLOT_ARMED    = 2'd2
  } slot_state_e;

  // Slot index width; a single slot still needs a 1-bit select.
  function automatic int sel_w(input int n_pat);
    return (n_pat > 1) ? $clog2(n_pat) : 1;
  endfunction

  // Width that holds a length or fill count in 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/pattern_detector_multi_if.sv
// Board-side bus of the pattern detector: serial input, slot programming, LED outputs.
interface pattern_detector_multi_if
  import pattern_detector_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int N_PAT = 2,
  parameter int LED_W = 5,
  parameter int CNT_W = 8
);
  localparam int SEL_W = sel_w(N_PAT);
  localparam int LEN_W = len_w(PAT_W);

  logic             data;
  logic             trig;
  logic             overlap;
  logic             pat_we;
  logic [SEL_W-1:0] pat_sel;
  logic [PAT_W-1:0] pat_val;
  logic [LEN_W-1:0] pat_len;
  logic             cnt_clr;
  logic [LED_W-1:0] led;
  logic [N_PAT-1:0] match;
  logic             on_led;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output data, trig, overlap, pat_we, pat_sel, pat_val, pat_len, cnt_clr,
    input  led, match, on_led, match_cnt
  );

  modport slave (
    input  data, trig, overlap, pat_we, pat_sel, pat_val, pat_len, cnt_clr,
    output led, match, on_led, match_cnt
  );

endinterface

// File: rtl/pattern_slot.sv
// One programmable pattern slot: holds val/len/fill, compares against the
// post-shift history and registers a one-cycle match pulse.
module pattern_slot
  import pattern_detector_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic [PAT_W-1:0] hist,     // history including the bit being accepted
  input  logic             overlap,
  input  logic             we,
  input  logic [PAT_W-1:0] wval,
  input  logic [LEN_W-1:0] wlen,     // already clamped to PAT_W
  output logic             hit,      // combinational: this accept edge matches
  output logic             match
);

  slot_state_e      state_q, state_d;
  logic [PAT_W-1:0] val_q, val_d, mask;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_inc;

  // Slot registers: everything cleared, slot comes up disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_DISABLED;
      val_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      match   <= hit;
    end
  end

  // Compare, fill update and next state; a write to this slot beats an accept.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    len_d   = len_q;
    fill_d  = fill_q;
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (LEN_W'(i) < len_q);
    fill_inc = (fill_q >= LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    hit = accept && !we && (state_q != SLOT_DISABLED) && (fill_inc >= len_q) &&
          (((hist ^ val_q) & mask) == '0);
    if (we) begin
      val_d   = wval;
      len_d   = wlen;
      fill_d  = '0;
      state_d = (wlen == '0) ? SLOT_DISABLED : SLOT_FILLING;
    end else if (accept) begin
      fill_d = (hit && !overlap) ? '0 : fill_inc;
      case (state_q)
        SLOT_DISABLED: state_d = SLOT_DISABLED;
        default:       state_d = (fill_d >= len_q) ? SLOT_ARMED : SLOT_FILLING;
      endcase
    end
  end

endmodule

// File: rtl/pattern_detector_multi.sv
// Serial bit-pattern detector with N_PAT programmable slots sharing one history.
// One bit is accepted per rising edge of trig; matches drive pulses, a stretched
// LED and a saturating counter.
module pattern_detector_multi
  import pattern_detector_pkg::*;
#(
  parameter int PAT_W   = 5,
  parameter int N_PAT   = 2,
  parameter int LED_W   = 5,
  parameter int ON_HOLD = 8,
  parameter int CNT_W   = 8
) (
  input logic                    clk,
  input logic                    reset,
  pattern_detector_multi_if.slave bus
);
  localparam int LEN_W  = len_w(PAT_W);
  localparam int SEL_W  = sel_w(N_PAT);
  localparam int HOLD_W = $clog2(ON_HOLD + 1);

  logic              trig_q, accept, any_hit;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]  wlen;
  logic [N_PAT-1:0]  hit, match_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt_q;

  assign accept  = bus.trig && !trig_q;
  assign hist_d  = accept ? {hist_q[PAT_W-2:0], bus.data} : hist_q;
  assign wlen    = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
  assign any_hit = |hit;

  // Strobe edge detect and shared bit history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= 1'b0;
      hist_q <= '0;
    end else begin
      trig_q <= bus.trig;
      hist_q <= hist_d;
    end
  end

  // on_led stretch: reload on any match, otherwise count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              hold_q <= '0;
    else if (any_hit)       hold_q <= HOLD_W'(ON_HOLD);
    else if (hold_q != '0)  hold_q <= hold_q - HOLD_W'(1);
  end

  // Saturating count of accept edges with at least one match; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt_q <= '0;
    else if (bus.cnt_clr)            cnt_q <= '0;
    else if (any_hit && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  for (genvar s = 0; s < N_PAT; s++) begin : g_slot
    pattern_slot #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .accept  (accept),
      .hist    (hist_d),
      .overlap (bus.overlap),
      .we      (bus.pat_we && (bus.pat_sel == SEL_W'(s))),
      .wval    (bus.pat_val),
      .wlen    (wlen),
      .hit     (hit[s]),
      .match   (match_q[s])
    );
  end

  assign bus.led       = hist_q[LED_W-1:0];
  assign bus.match     = match_q;
  assign bus.on_led    = (hold_q != '0);
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_detector_multi.sv
// Directed bench for pattern_detector_multi (PAT_W=5, N_PAT=2, LED_W=5, ON_HOLD=8, CNT_W=2).
module tb_pattern_detector_multi;
  localparam int PAT_W = 5, N_PAT = 2, LED_W = 5, ON_HOLD = 8, CNT_W = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pattern_detector_multi_if #(.PAT_W(PAT_W), .N_PAT(N_PAT), .LED_W(LED_W), .CNT_W(CNT_W)) bus ();

  pattern_detector_multi #(
    .PAT_W(PAT_W), .N_PAT(N_PAT), .LED_W(LED_W), .ON_HOLD(ON_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.data    = 1'b0;
    bus.trig    = 1'b0;
    bus.overlap = 1'b0;
    bus.pat_we  = 1'b0;
    bus.pat_sel = '0;
    bus.pat_val = '0;
    bus.pat_len = '0;
    bus.cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_slot(input int sel, input logic [4:0] val, input logic [2:0] len);
    @(negedge clk);
    bus.pat_we  = 1'b1;
    bus.pat_sel = 1'(sel);
    bus.pat_val = val;
    bus.pat_len = len;
    @(negedge clk);
    bus.pat_we  = 1'b0;
  endtask

  // One strobe: rise with data, sample match after the accept edge, then drop trig.
  task automatic send_bit(input logic d, output logic [N_PAT-1:0] m);
    @(negedge clk);
    bus.data = d;
    bus.trig = 1'b1;
    @(negedge clk);
    m = bus.match;
    bus.trig = 1'b0;
    @(negedge clk);
  endtask

  // Sends n bits, first bit = bits[n-1]; expected match bits use the same ordering.
  task automatic run_stream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp0, input logic [15:0] exp1);
    logic [N_PAT-1:0] m;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i], m);
      chk($sformatf("%s m0 bit%0d", tag, n - i), 32'(m[0]), 32'(exp0[i]));
      chk($sformatf("%s m1 bit%0d", tag, n - i), 32'(m[1]), 32'(exp1[i]));
    end
  endtask

  initial begin
    logic [N_PAT-1:0] m;

    // Reset state
    do_reset();
    chk("rst led", 32'(bus.led), 32'h0);
    chk("rst match", 32'(bus.match), 32'h0);
    chk("rst on_led", 32'(bus.on_led), 32'h0);
    chk("rst cnt", 32'(bus.match_cnt), 32'h0);

    // 1: overlapping 1011 matches after bits 4 and 7
    write_slot(0, 5'b01011, 3'd4);
    bus.overlap = 1'b1;
    run_stream("t1", 16'b1011011, 7, 16'b0001001, 16'b0);
    chk("t1 cnt", 32'(bus.match_cnt), 32'd2);
    chk("t1 led", 32'(bus.led), 32'b11011);
    chk("t1 on_led held", 32'(bus.on_led), 32'h1);
    repeat (6) @(negedge clk);
    chk("t1 on_led last", 32'(bus.on_led), 32'h1);
    @(negedge clk);
    chk("t1 on_led off", 32'(bus.on_led), 32'h0);

    // 2: non-overlapping, second occurrence suppressed
    do_reset();
    write_slot(0, 5'b01011, 3'd4);
    bus.overlap = 1'b0;
    run_stream("t2", 16'b1011011, 7, 16'b0001000, 16'b0);
    chk("t2 cnt", 32'(bus.match_cnt), 32'd1);

    // 3: trig held high three cycles accepts exactly one bit
    do_reset();
    write_slot(0, 5'b01011, 3'd4);
    @(negedge clk);
    bus.data = 1'b1;
    bus.trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3 match c%0d", i), 32'(bus.match), 32'h0);
    end
    bus.trig = 1'b0;
    @(negedge clk);
    chk("t3 led", 32'(bus.led), 32'b00001);
    chk("t3 cnt", 32'(bus.match_cnt), 32'h0);

    // 4: len 0 disables; len 7 clamps to 5
    do_reset();
    bus.overlap = 1'b1;
    write_slot(1, 5'b00001, 3'd0);
    run_stream("t4a", 16'b111, 3, 16'b0, 16'b0);
    write_slot(1, 5'b10101, 3'd7);
    run_stream("t4b", 16'b10101, 5, 16'b0, 16'b00001);

    // 5: counter saturates at 3; clear beats a simultaneous match
    do_reset();
    bus.overlap = 1'b1;
    write_slot(0, 5'b00001, 3'd1);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, m);
      chk($sformatf("t5 m0 bit%0d", i + 1), 32'(m[0]), 32'h1);
      chk($sformatf("t5 cnt bit%0d", i + 1), 32'(bus.match_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    @(negedge clk);
    bus.data    = 1'b1;
    bus.trig    = 1'b1;
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    chk("t5 clr match", 32'(bus.match[0]), 32'h1);
    chk("t5 clr cnt", 32'(bus.match_cnt), 32'h0);
    bus.cnt_clr = 1'b0;
    bus.trig    = 1'b0;
    send_bit(1'b1, m);
    chk("t5 after clr cnt", 32'(bus.match_cnt), 32'd1);

    // 6: async reset mid-strobe clears outputs and disables slots
    do_reset();
    bus.overlap = 1'b1;
    write_slot(0, 5'b00001, 3'd1);
    run_stream("t6a", 16'b111, 3, 16'b111, 16'b0);
    @(negedge clk);
    bus.data = 1'b1;
    bus.trig = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("t6 rst led", 32'(bus.led), 32'h0);
    chk("t6 rst on_led", 32'(bus.on_led), 32'h0);
    chk("t6 rst match", 32'(bus.match), 32'h0);
    chk("t6 rst cnt", 32'(bus.match_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6 held strobe led", 32'(bus.led), 32'b00001);
    chk("t6 held strobe match", 32'(bus.match), 32'h0);
    bus.trig = 1'b0;
    run_stream("t6b", 16'b11, 2, 16'b0, 16'b0);
    chk("t6 led", 32'(bus.led), 32'b00111);
    chk("t6 cnt", 32'(bus.match_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
